// File: rtl/framebuffer_multibank.sv
// framebuffer_multibank: multi-bank palette-index framebuffer with frame-synchronous swap.
// Optional back-bank clear engine is built when FB_CLEAR_EN is defined.
module framebuffer_multibank #(
  parameter int RESOLUTION_X   = 400,
  parameter int RESOLUTION_Y   = 300,
  parameter int PALETTE_LENGTH = 256,
  parameter int NUM_BUFFERS    = 2,
  localparam int PW = $clog2(PALETTE_LENGTH),
  localparam int BW = $clog2(NUM_BUFFERS),
  localparam int XW = $clog2(RESOLUTION_X),
  localparam int YW = $clog2(RESOLUTION_Y)
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          re_i,
  input  logic [XW-1:0] pxl_x_i,
  input  logic [YW-1:0] pxl_y_i,
  output logic [PW-1:0] palette_index_o,
  input  logic          we_i,
  input  logic [XW-1:0] wr_pxl_x_i,
  input  logic [YW-1:0] wr_pxl_y_i,
  input  logic [PW-1:0] wr_palette_index_i,
  output logic          wr_ready_o,
  input  logic          swap_req_i,
  input  logic          frame_start_i,
  output logic          swap_pending_o,
  output logic          swap_done_o,
  output logic [BW-1:0] front_sel_o,
  input  logic          clear_start_i,
  input  logic [PW-1:0] clear_value_i,
  output logic          clear_busy_o,
  output logic          clear_done_o
);
  localparam int DEPTH = RESOLUTION_X * RESOLUTION_Y;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_PEND} swap_state_t;

  swap_state_t   r_swap_state, w_swap_next;
  logic [BW-1:0] r_front, w_back;
  logic          r_swap_done, w_commit;
  logic [PW-1:0] r_mem [NUM_BUFFERS][DEPTH];
  logic [PW-1:0] r_rd_data;
  logic          w_rd_ok, w_wr_ok, w_we;
  logic [AW-1:0] w_rd_addr, w_wr_addr, w_waddr;
  logic [BW-1:0] w_wbank;
  logic [PW-1:0] w_wdata;
  logic          w_clr_busy, w_clr_we, w_clr_done;
  logic [BW-1:0] w_clr_bank;
  logic [AW-1:0] w_clr_addr;
  logic [PW-1:0] w_clr_data;

  assign w_back    = (r_front == BW'(NUM_BUFFERS - 1)) ? '0 : r_front + 1'b1;
  assign w_rd_ok   = re_i && int'(pxl_x_i) < RESOLUTION_X && int'(pxl_y_i) < RESOLUTION_Y;
  assign w_rd_addr = AW'(RESOLUTION_X * int'(pxl_y_i) + int'(pxl_x_i));
  assign w_wr_ok   = we_i && !w_clr_busy && int'(wr_pxl_x_i) < RESOLUTION_X && int'(wr_pxl_y_i) < RESOLUTION_Y;
  assign w_wr_addr = AW'(RESOLUTION_X * int'(wr_pxl_y_i) + int'(wr_pxl_x_i));

`ifdef FB_CLEAR_EN
  typedef enum logic {C_IDLE, C_RUN} clr_state_t;

  clr_state_t    r_clr_state, w_clr_next;
  logic [AW-1:0] r_clr_cnt;
  logic [PW-1:0] r_clr_val;
  logic [BW-1:0] r_clr_bank;
  logic          r_clr_done, w_clr_last;

  always_comb begin
    w_clr_last = r_clr_cnt == AW'(DEPTH - 1);
    w_clr_next = r_clr_state;
    if (r_clr_state == C_IDLE && clear_start_i) w_clr_next = C_RUN;
    else if (r_clr_state == C_RUN && w_clr_last) w_clr_next = C_IDLE;
  end

  // target bank is frozen at start; swaps are held off until the fill completes
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_clr_state <= C_IDLE;
      r_clr_cnt   <= '0;
      r_clr_val   <= '0;
      r_clr_bank  <= '0;
      r_clr_done  <= 1'b0;
    end else begin
      r_clr_state <= w_clr_next;
      r_clr_done  <= r_clr_state == C_RUN && w_clr_last;
      if (r_clr_state == C_IDLE && clear_start_i) begin
        r_clr_cnt  <= '0;
        r_clr_val  <= clear_value_i;
        r_clr_bank <= w_back;
      end else if (r_clr_state == C_RUN) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end
    end
  end

  assign w_clr_busy = r_clr_state == C_RUN;
  assign w_clr_we   = w_clr_busy;
  assign w_clr_bank = r_clr_bank;
  assign w_clr_addr = r_clr_cnt;
  assign w_clr_data = r_clr_val;
  assign w_clr_done = r_clr_done;
`else
  logic w_unused;
  assign w_unused   = ^{clear_start_i, clear_value_i};
  assign w_clr_busy = 1'b0;
  assign w_clr_we   = 1'b0;
  assign w_clr_bank = '0;
  assign w_clr_addr = '0;
  assign w_clr_data = '0;
  assign w_clr_done = 1'b0;
`endif

  assign w_we    = w_clr_we || w_wr_ok;
  assign w_wbank = w_clr_we ? w_clr_bank : w_back;
  assign w_waddr = w_clr_we ? w_clr_addr : w_wr_addr;
  assign w_wdata = w_clr_we ? w_clr_data : wr_palette_index_i;

  always_ff @(posedge clk_i) begin
    if (w_we) r_mem[w_wbank][w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) r_rd_data <= '0;
    else r_rd_data <= w_rd_ok ? r_mem[r_front][w_rd_addr] : '0;
  end

  always_comb begin
    w_commit    = r_swap_state == S_PEND && frame_start_i && !w_clr_busy;
    w_swap_next = r_swap_state == S_IDLE ? (swap_req_i ? S_PEND : S_IDLE)
                                         : (w_commit ? S_IDLE : S_PEND);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_swap_state <= S_IDLE;
      r_front      <= '0;
      r_swap_done  <= 1'b0;
    end else begin
      r_swap_state <= w_swap_next;
      r_swap_done  <= w_commit;
      if (w_commit) r_front <= w_back;
    end
  end

  assign palette_index_o = r_rd_data;
  assign wr_ready_o      = !w_clr_busy;
  assign swap_pending_o  = r_swap_state == S_PEND;
  assign swap_done_o     = r_swap_done;
  assign front_sel_o     = r_front;
  assign clear_busy_o    = w_clr_busy;
  assign clear_done_o    = w_clr_done;
endmodule

// File: tb/tb_framebuffer_multibank.sv
// tb_framebuffer_multibank: random + directed stimulus against a bank-array reference model.
// Clear-engine checks are enabled when FB_CLEAR_EN is defined.
module tb_framebuffer_multibank;
  localparam int RX = 8, RY = 4, PL = 256, N = 2, D = RX * RY;
  localparam int PW = $clog2(PL), BW = $clog2(N), XW = $clog2(RX), YW = $clog2(RY);
  localparam int RX2 = 6, RY2 = 3, N2 = 3;
  localparam int XW2 = $clog2(RX2), YW2 = $clog2(RY2), BW2 = $clog2(N2);
`ifdef FB_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_ni, re, we, swap_req, frame_start, clear_start;
  logic [XW-1:0] pxl_x, wx;
  logic [YW-1:0] pxl_y, wy;
  logic [PW-1:0] wd, clear_value, palette_index;
  logic wr_ready, swap_pending, swap_done, clear_busy, clear_done;
  logic [BW-1:0] front_sel;

  logic d2_re, d2_we, d2_req, d2_fs;
  logic [XW2-1:0] d2_x, d2_wx;
  logic [YW2-1:0] d2_y, d2_wy;
  logic [PW-1:0] d2_wd, d2_pix;
  logic d2_ready, d2_pend, d2_done, d2_cbusy, d2_cdone;
  logic [BW2-1:0] d2_front;

  framebuffer_multibank #(.RESOLUTION_X(RX), .RESOLUTION_Y(RY), .PALETTE_LENGTH(PL), .NUM_BUFFERS(N)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .re_i(re), .pxl_x_i(pxl_x), .pxl_y_i(pxl_y),
    .palette_index_o(palette_index), .we_i(we), .wr_pxl_x_i(wx), .wr_pxl_y_i(wy),
    .wr_palette_index_i(wd), .wr_ready_o(wr_ready), .swap_req_i(swap_req),
    .frame_start_i(frame_start), .swap_pending_o(swap_pending), .swap_done_o(swap_done),
    .front_sel_o(front_sel), .clear_start_i(clear_start), .clear_value_i(clear_value),
    .clear_busy_o(clear_busy), .clear_done_o(clear_done));

  framebuffer_multibank #(.RESOLUTION_X(RX2), .RESOLUTION_Y(RY2), .PALETTE_LENGTH(PL), .NUM_BUFFERS(N2)) dut2 (
    .clk_i(clk), .reset_ni(reset_ni), .re_i(d2_re), .pxl_x_i(d2_x), .pxl_y_i(d2_y),
    .palette_index_o(d2_pix), .we_i(d2_we), .wr_pxl_x_i(d2_wx), .wr_pxl_y_i(d2_wy),
    .wr_palette_index_i(d2_wd), .wr_ready_o(d2_ready), .swap_req_i(d2_req),
    .frame_start_i(d2_fs), .swap_pending_o(d2_pend), .swap_done_o(d2_done),
    .front_sel_o(d2_front), .clear_start_i(1'b0), .clear_value_i(8'h00),
    .clear_busy_o(d2_cbusy), .clear_done_o(d2_cdone));

  int n_vec = 0, n_err = 0;
  int m_mem [N][D];
  int m_front = 0, m_cnt = 0, m_cbank = 0, m_cval = 0;
  bit m_pend = 0, m_run = 0;
  int e_rd = 0;
  bit e_sdone = 0, e_cdone = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // model advances from the inputs presented this cycle, then outputs are checked after the edge
  task automatic step();
    bit busy;
    int bk;
    busy = m_run;
    bk = (m_front + 1) % N;
    e_rd = (re && int'(pxl_x) < RX && int'(pxl_y) < RY) ? m_mem[m_front][int'(pxl_y) * RX + int'(pxl_x)] : 0;
    if (we && !busy && int'(wx) < RX && int'(wy) < RY) m_mem[bk][int'(wy) * RX + int'(wx)] = int'(wd);
    e_cdone = 1'b0;
    if (busy) begin
      m_mem[m_cbank][m_cnt] = m_cval;
      m_cnt++;
      if (m_cnt == D) begin
        m_run = 1'b0;
        e_cdone = 1'b1;
      end
    end else if (CLR && clear_start) begin
      m_run = 1'b1;
      m_cnt = 0;
      m_cbank = bk;
      m_cval = int'(clear_value);
    end
    e_sdone = m_pend && frame_start && !busy;
    if (e_sdone) begin
      m_pend = 1'b0;
      m_front = (m_front + 1) % N;
    end else if (!m_pend && swap_req) m_pend = 1'b1;
    @(posedge clk);
    #1;
    chk("rd", palette_index, e_rd);
    chk("pend", swap_pending, m_pend);
    chk("sdone", swap_done, e_sdone);
    chk("front", front_sel, m_front);
    chk("cbusy", clear_busy, m_run);
    chk("wrdy", wr_ready, !m_run);
    chk("cdone", clear_done, e_cdone);
  endtask

  task automatic swap_pair();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  initial begin
    reset_ni = 1'b1;
    {re, we, swap_req, frame_start, clear_start} = '0;
    {pxl_x, pxl_y, wx, wy, wd, clear_value} = '0;
    {d2_re, d2_we, d2_req, d2_fs, d2_x, d2_y, d2_wx, d2_wy, d2_wd} = '0;
    #2 reset_ni = 1'b0;
    #1;
    chk("rst_rd", palette_index, 0);
    chk("rst_front", front_sel, 0);
    chk("rst_pend", swap_pending, 0);
    chk("rst_sdone", swap_done, 0);
    chk("rst_busy", clear_busy, 0);
    chk("rst_cdone", clear_done, 0);
    chk("rst_wrdy", wr_ready, 1);
    #20 reset_ni = 1'b1;
    @(posedge clk);
    #1;

    // three-bank instance: out-of-range accesses and rotation order
    d2_we = 1'b1; d2_wx = 1; d2_wy = 1; d2_wd = 8'h22;
    step();
    d2_wx = 7; d2_wy = 0; d2_wd = 8'hEE;
    step();
    d2_wx = 0; d2_wy = 3;
    step();
    d2_we = 1'b0; d2_req = 1'b1;
    step();
    d2_req = 1'b0; d2_fs = 1'b1;
    step();
    d2_fs = 1'b0;
    chk("d2_done", d2_done, 1);
    chk("d2_front1", d2_front, 1);
    d2_re = 1'b1; d2_x = 1; d2_y = 1;
    step();
    chk("d2_rd", d2_pix, 8'h22);
    d2_x = 7; d2_y = 0;
    step();
    chk("d2_oor_x", d2_pix, 0);
    d2_x = 0; d2_y = 3;
    step();
    chk("d2_oor_y", d2_pix, 0);
    d2_re = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d2_req = 1'b1;
      step();
      d2_req = 1'b0; d2_fs = 1'b1;
      step();
      d2_fs = 1'b0;
      chk("d2_seq", d2_front, (i + 2) % 3);
    end
    chk("d2_wrdy", d2_ready, 1);

    // fill every bank so later reads are defined
    for (int b = 0; b < N; b++) begin
      we = 1'b1;
      for (int a = 0; a < D; a++) begin
        wx = XW'(a % RX); wy = YW'(a / RX); wd = PW'($urandom_range(255));
        step();
      end
      we = 1'b0;
      swap_pair();
    end

    we = 1'b1; wx = 3; wy = 2; wd = 8'h5A;
    step();
    we = 1'b0;
    swap_pair();
    chk("t1_done", swap_done, 1);
    chk("t1_front", front_sel, 1);
    re = 1'b1; pxl_x = 3; pxl_y = 2;
    step();
    chk("t1_rd", palette_index, 8'h5A);
    re = 1'b0;
    step();
    chk("t2_re0", palette_index, 0);

    swap_req = 1'b1; frame_start = 1'b1;
    step();
    swap_req = 1'b0;
    chk("t3_front", front_sel, 1);
    chk("t3_pend", swap_pending, 1);
    step();
    frame_start = 1'b0;
    chk("t3_done", swap_done, 1);
    chk("t3_front2", front_sel, 0);

`ifdef FB_CLEAR_EN
    begin
      int nb;
      clear_start = 1'b1; clear_value = 8'h11;
      step();
      clear_start = 1'b0;
      nb = 0;
      while (clear_busy === 1'b1 && nb < 40) begin
        we = (nb == 3); wx = 1; wy = 1; wd = 8'h77;
        swap_req = (nb == 5);
        frame_start = (nb == 10);
        step();
        nb++;
      end
      {we, swap_req, frame_start} = '0;
      chk("t4_len", nb, 32);
      chk("t4_done", clear_done, 1);
      chk("t4_pend", swap_pending, 1);
      chk("t4_front", front_sel, 0);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk("t4_swap", swap_done, 1);
      re = 1'b1;
      for (int a = 0; a < D; a++) begin
        pxl_x = XW'(a % RX); pxl_y = YW'(a / RX);
        step();
        chk("t4_rd", palette_index, 8'h11);
      end
      re = 1'b0;
      clear_start = 1'b1; clear_value = 8'h33;
      step();
      clear_start = 1'b0;
    end
`else
    clear_start = 1'b1; clear_value = 8'h11;
    step();
    clear_start = 1'b0;
    chk("t6_busy", clear_busy, 0);
    chk("t6_wrdy", wr_ready, 1);
    swap_pair();
`endif
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    re = 1'b1; pxl_x = 2; pxl_y = 1;
    step();
    step();
    re = 1'b0;
    #2 reset_ni = 1'b0;
    #1;
    chk("t5_rd", palette_index, 0);
    chk("t5_front", front_sel, 0);
    chk("t5_pend", swap_pending, 0);
    chk("t5_sdone", swap_done, 0);
    chk("t5_busy", clear_busy, 0);
    chk("t5_cdone", clear_done, 0);
    chk("t5_wrdy", wr_ready, 1);
    m_front = 0; m_pend = 1'b0; m_run = 1'b0;
    reset_ni = 1'b1;

    for (int i = 0; i < 1500; i++) begin
      re = ($urandom_range(3) != 0);
      pxl_x = XW'($urandom_range(RX - 1)); pxl_y = YW'($urandom_range(RY - 1));
      we = $urandom_range(1);
      wx = XW'($urandom_range(RX - 1)); wy = YW'($urandom_range(RY - 1));
      wd = PW'($urandom_range(255));
      swap_req = ($urandom_range(9) == 0);
      frame_start = ($urandom_range(9) == 0);
      clear_start = ($urandom_range(99) == 0);
      clear_value = PW'($urandom_range(255));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
